// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus interface: dispatch, CDB writeback, flush, operand view and commit.
// master = dispatch/FU/RF side, slave = reorder_buffer.
interface reorder_buffer_if #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned DISPATCH_W = 4,
    parameter int unsigned CDB_W      = 4,
    parameter int unsigned COMMIT_W   = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_W      = 4
);
    logic [DISPATCH_W-1:0]        disp_valid;
    logic [DISPATCH_W*REG_W-1:0]  disp_rt;
    logic                         disp_ready;
    logic [DISPATCH_W*TAG_W-1:0]  disp_tags;
    logic [CDB_W-1:0]             cdb_valid;
    logic [CDB_W*TAG_W-1:0]       cdb_tag;
    logic [CDB_W*DATA_W-1:0]      cdb_data;
    logic                         flush_valid;
    logic [TAG_W-1:0]             flush_tag;
    logic [DEPTH-1:0]             out_finished;
    logic [DEPTH*DATA_W-1:0]      out_values;
    logic [COMMIT_W-1:0]          commit_en;
    logic [COMMIT_W*REG_W-1:0]    commit_rt;
    logic [COMMIT_W*DATA_W-1:0]   commit_data;
    logic [COMMIT_W*TAG_W-1:0]    commit_tag;
    logic [TAG_W-1:0]             head;
    logic [TAG_W:0]               count;

    modport master (
        output disp_valid, disp_rt, cdb_valid, cdb_tag, cdb_data, flush_valid, flush_tag,
        input  disp_ready, disp_tags, out_finished, out_values,
               commit_en, commit_rt, commit_data, commit_tag, head, count
    );

    modport slave (
        input  disp_valid, disp_rt, cdb_valid, cdb_tag, cdb_data, flush_valid, flush_tag,
        output disp_ready, disp_tags, out_finished, out_values,
               commit_en, commit_rt, commit_data, commit_tag, head, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// Parametrised reorder buffer: in-order allocation at dispatch, out-of-order completion
// from the CDB, in-order retirement, and branch-mispredict flush of younger entries.
// Optional macro ROB_CDB_FORWARD_EN: out_finished/out_values bypass same-cycle CDB writes.
module reorder_buffer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned DISPATCH_W = 4,
    parameter int unsigned CDB_W      = 4,
    parameter int unsigned COMMIT_W   = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_W      = 4
) (
    input logic             clk,
    input logic             rst_n,
    reorder_buffer_if.slave rob
);
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [TAG_W:0]   cnt_t;

    // Registered entry and pointer state
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [REG_W-1:0]  rt_q  [DEPTH];
    logic [REG_W-1:0]  rt_d  [DEPTH];
    logic [DATA_W-1:0] val_q [DEPTH];
    logic [DATA_W-1:0] val_d [DEPTH];
    tag_t              head_q, head_d;
    tag_t              tail_q, tail_d;
    cnt_t              count_q, count_d;

    // Combinational helpers
    logic              disp_ready_w;
    logic              flush_eff;
    logic              disp_fire;
    tag_t              flush_age;
    cnt_t              n_disp;
    cnt_t              n_commit;
    logic [COMMIT_W-1:0] commit_en_w;
    logic [DEPTH-1:0]  cdb_hit;
    logic [DATA_W-1:0] cdb_val [DEPTH];
    logic [DEPTH-1:0]  squash;

    // Readiness uses registered occupancy only; commits this cycle are not credited.
    assign disp_ready_w = (count_q <= cnt_t'(DEPTH - DISPATCH_W));
    // A flush naming an unoccupied entry is ignored entirely.
    assign flush_eff    = rob.flush_valid && valid_q[rob.flush_tag];
    assign flush_age    = rob.flush_tag - head_q;
    assign disp_fire    = disp_ready_w && !flush_eff;

    assign rob.disp_ready = disp_ready_w;
    assign rob.head       = head_q;
    assign rob.count      = count_q;
    assign rob.commit_en  = commit_en_w;

    // Tags offered to each dispatch slot and number of slots accepted this cycle
    always_comb begin
        rob.disp_tags = '0;
        n_disp        = '0;
        for (int unsigned i = 0; i < DISPATCH_W; i++) begin
            rob.disp_tags[i*TAG_W +: TAG_W] = tail_q + TAG_W'(i);
            if (disp_fire && rob.disp_valid[i]) begin
                n_disp = n_disp + cnt_t'(1);
            end
        end
    end

    // Per-entry CDB match; scanning lanes upward so the lowest lane wins on duplicates
    always_comb begin
        cdb_hit = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            cdb_val[e] = '0;
        end
        for (int unsigned e = 0; e < DEPTH; e++) begin
            for (int unsigned l = 0; l < CDB_W; l++) begin
                if (!cdb_hit[e] && rob.cdb_valid[l] &&
                    rob.cdb_tag[l*TAG_W +: TAG_W] == TAG_W'(e)) begin
                    cdb_hit[e] = 1'b1;
                    cdb_val[e] = rob.cdb_data[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Entries strictly younger than the flushed branch (age measured from head)
    always_comb begin
        squash = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (flush_eff && ((TAG_W'(e) - head_q) > flush_age)) begin
                squash[e] = 1'b1;
            end
        end
    end

    // In-order retirement lanes; during a flush only the branch and older entries retire
    always_comb begin
        logic chain;
        chain           = 1'b1;
        commit_en_w     = '0;
        n_commit        = '0;
        rob.commit_rt   = '0;
        rob.commit_data = '0;
        rob.commit_tag  = '0;
        for (int unsigned i = 0; i < COMMIT_W; i++) begin
            chain = chain && valid_q[head_q + TAG_W'(i)] && done_q[head_q + TAG_W'(i)] &&
                    (!flush_eff || (TAG_W'(i) <= flush_age));
            commit_en_w[i] = chain;
            rob.commit_rt[i*REG_W +: REG_W]    = rt_q[head_q + TAG_W'(i)];
            rob.commit_data[i*DATA_W +: DATA_W] = val_q[head_q + TAG_W'(i)];
            rob.commit_tag[i*TAG_W +: TAG_W]    = head_q + TAG_W'(i);
            if (chain) begin
                n_commit = n_commit + cnt_t'(1);
            end
        end
    end

    // Operand-capture view of finished entries
    always_comb begin
        rob.out_finished = '0;
        rob.out_values   = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
`ifdef ROB_CDB_FORWARD_EN
            rob.out_finished[e] = valid_q[e] && (done_q[e] || cdb_hit[e]);
            rob.out_values[e*DATA_W +: DATA_W] = cdb_hit[e] ? cdb_val[e] : val_q[e];
`else
            rob.out_finished[e] = valid_q[e] && done_q[e];
            rob.out_values[e*DATA_W +: DATA_W] = val_q[e];
`endif
        end
    end

    // Next entry state: completion, then retirement and squash, then allocation.
    // Dispatch slots are always free entries, so they never collide with the other updates.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rt_d    = rt_q;
        val_d   = val_q;
        head_d  = head_q + n_commit[TAG_W-1:0];
        tail_d  = tail_q;
        count_d = count_q;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (valid_q[e] && cdb_hit[e] && !squash[e]) begin
                done_d[e] = 1'b1;
                val_d[e]  = cdb_val[e];
            end
        end
        for (int unsigned i = 0; i < COMMIT_W; i++) begin
            if (commit_en_w[i]) begin
                valid_d[head_q + TAG_W'(i)] = 1'b0;
            end
        end
        valid_d = valid_d & ~squash;
        if (flush_eff) begin
            tail_d  = rob.flush_tag + TAG_W'(1);
            count_d = {1'b0, flush_age} + cnt_t'(1) - n_commit;
        end else begin
            for (int unsigned i = 0; i < DISPATCH_W; i++) begin
                if (disp_fire && rob.disp_valid[i]) begin
                    valid_d[tail_q + TAG_W'(i)] = 1'b1;
                    done_d[tail_q + TAG_W'(i)]  = 1'b0;
                    rt_d[tail_q + TAG_W'(i)]    = rob.disp_rt[i*REG_W +: REG_W];
                end
            end
            tail_d  = tail_q + n_disp[TAG_W-1:0];
            count_d = count_q + n_disp - n_commit;
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                rt_q[e]  <= '0;
                val_q[e] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rt_q    <= rt_d;
            val_q   <= val_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: dispatched entries are queued in program order,
// retired lanes are popped and compared; occupancy, head, readiness, tags and the
// finished view are predicted every cycle from the bench's own model.
`timescale 1ns/1ps
module tb_reorder_buffer;
    localparam int DEPTH = 16;
    localparam int DW    = 4;
    localparam int CW    = 4;
    localparam int KW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    reorder_buffer_if #(.DEPTH(16), .TAG_W(4), .DISPATCH_W(4), .CDB_W(4),
                        .COMMIT_W(4), .DATA_W(16), .REG_W(4)) rob_bus ();

    reorder_buffer #(.DEPTH(16), .TAG_W(4), .DISPATCH_W(4), .CDB_W(4),
                     .COMMIT_W(4), .DATA_W(16), .REG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rob   (rob_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tag;
        logic [3:0] rt;
    } ent_t;

    ent_t        q[$];
    logic [15:0] exp_data [16];
    logic        exp_done [16];
    logic [3:0]  m_head;
    logic [3:0]  m_tail;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int qpos(input logic [3:0] t);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].tag == t) return i;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        rob_bus.disp_valid  = '0;
        rob_bus.disp_rt     = '0;
        rob_bus.cdb_valid   = '0;
        rob_bus.cdb_tag     = '0;
        rob_bus.cdb_data    = '0;
        rob_bus.flush_valid = 1'b0;
        rob_bus.flush_tag   = '0;
    endtask

    task automatic disp(input int n, input logic [15:0] rts);
        logic [3:0] m;
        m = 4'((1 << n) - 1);
        rob_bus.disp_valid = m;
        rob_bus.disp_rt    = rts;
    endtask

    task automatic cdb(input int lane, input logic [3:0] tag, input logic [15:0] data);
        rob_bus.cdb_valid[lane]         = 1'b1;
        rob_bus.cdb_tag[lane*4 +: 4]    = tag;
        rob_bus.cdb_data[lane*16 +: 16] = data;
    endtask

    task automatic flush(input logic [3:0] tag);
        rob_bus.flush_valid = 1'b1;
        rob_bus.flush_tag   = tag;
    endtask

    // One clock: called just after a falling edge with this cycle's inputs applied.
    task automatic cycle();
        int          fpos;
        int          n;
        int          pos;
        int          pre_size;
        logic        ready;
        logic        hit;
        logic [15:0] fval;
        logic [15:0] efin;
        logic [15:0] etags;
        logic [15:0] hitmask;
        logic [3:0]  t;
        ent_t        e;
        #3;
        pre_size = q.size();
        ready    = (pre_size <= DEPTH - DW);
        check("count", rob_bus.count, pre_size);
        check("head", rob_bus.head, m_head);
        check("disp_ready", rob_bus.disp_ready, ready);
        for (int i = 0; i < DW; i++) etags[i*4 +: 4] = m_tail + 4'(i);
        check("disp_tags", rob_bus.disp_tags, etags);
        efin = '0;
        for (int en = 0; en < DEPTH; en++) begin
            pos  = qpos(4'(en));
            hit  = 1'b0;
            fval = exp_data[en];
`ifdef ROB_CDB_FORWARD_EN
            for (int l = 0; l < CW; l++) begin
                if (!hit && rob_bus.cdb_valid[l] && rob_bus.cdb_tag[l*4 +: 4] == 4'(en)) begin
                    hit  = 1'b1;
                    fval = rob_bus.cdb_data[l*16 +: 16];
                end
            end
`endif
            efin[en] = (pos >= 0) && (exp_done[en] || hit);
            if (efin[en]) check("out_value", rob_bus.out_values[en*16 +: 16], fval);
        end
        check("out_finished", rob_bus.out_finished, efin);
        fpos = rob_bus.flush_valid ? qpos(rob_bus.flush_tag) : -1;
        n = 0;
        while (n < KW && n < q.size() && exp_done[q[n].tag] && (fpos < 0 || n <= fpos)) n++;
        check("commit_en", rob_bus.commit_en, (1 << n) - 1);
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            check("commit_tag", rob_bus.commit_tag[i*4 +: 4], e.tag);
            check("commit_rt", rob_bus.commit_rt[i*4 +: 4], e.rt);
            check("commit_data", rob_bus.commit_data[i*16 +: 16], exp_data[e.tag]);
            m_head++;
        end
        @(posedge clk);
        if (fpos >= 0) begin
            while (q.size() > fpos - n + 1) void'(q.pop_back());
            m_tail = rob_bus.flush_tag + 4'd1;
        end
        hitmask = '0;
        for (int l = 0; l < CW; l++) begin
            if (rob_bus.cdb_valid[l]) begin
                t = rob_bus.cdb_tag[l*4 +: 4];
                if (!hitmask[t]) begin
                    hitmask[t] = 1'b1;
                    if (qpos(t) >= 0) begin
                        exp_done[t] = 1'b1;
                        exp_data[t] = rob_bus.cdb_data[l*16 +: 16];
                    end
                end
            end
        end
        if (fpos < 0 && ready) begin
            for (int s = 0; s < DW; s++) begin
                if (rob_bus.disp_valid[s]) begin
                    e.tag = m_tail;
                    e.rt  = rob_bus.disp_rt[s*4 +: 4];
                    q.push_back(e);
                    exp_done[m_tail] = 1'b0;
                    m_tail++;
                end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    // Asynchronous reset applied between clock edges; state must clear immediately.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", rob_bus.count, 0);
        check("rst_head", rob_bus.head, 0);
        check("rst_commit_en", rob_bus.commit_en, 0);
        check("rst_out_finished", rob_bus.out_finished, 0);
        check("rst_disp_ready", rob_bus.disp_ready, 1);
        q.delete();
        m_head = '0;
        m_tail = '0;
        for (int i = 0; i < DEPTH; i++) exp_done[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Complete every outstanding entry and let them retire, with a cycle budget.
    task automatic drain();
        int guard;
        int k;
        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            k = 0;
            for (int i = 0; i < q.size() && k < CW; i++) begin
                if (!exp_done[q[i].tag]) begin
                    cdb(k, q[i].tag, 16'($urandom));
                    k++;
                end
            end
            cycle();
            guard++;
        end
        check("drain_left", q.size(), 0);
    endtask

    initial begin
        int          n;
        logic [3:0]  t;
        for (int i = 0; i < DEPTH; i++) begin
            exp_data[i] = '0;
            exp_done[i] = 1'b0;
        end
        m_head = '0;
        m_tail = '0;
        clear_inputs();
        @(negedge clk);
        do_reset();

        // Four slots, rt 1..4, then out-of-order completion of tags 1 and 0
        disp(4, 16'h4321);
        cycle();
        cycle();
        cdb(0, 4'd1, 16'hAAAA);
        cdb(1, 4'd0, 16'hBBBB);
        cycle();
        cycle();
        drain();

        // Fill to full, hold dispatch while entries retire one at a time
        for (int i = 0; i < 4; i++) begin
            disp(4, 16'($urandom));
            cycle();
        end
        disp(4, 16'h9999);
        cycle();
        for (int i = 0; i < 8; i++) begin
            disp(4, 16'($urandom));
            for (int j = 0; j < q.size(); j++) begin
                if (!exp_done[q[j].tag]) begin
                    cdb(0, q[j].tag, 16'($urandom));
                    break;
                end
            end
            cycle();
        end
        drain();

        // Mid-operation reset, then flush tag 3 with same-cycle dispatch and CDB to tag 5
        disp(4, 16'h1111);
        cycle();
        cdb(0, q[0].tag, 16'h5555);
        disp(2, 16'h0022);
        cycle();
        do_reset();
        disp(4, 16'h4321);
        cycle();
        disp(4, 16'h8765);
        cycle();
        flush(4'd3);
        disp(4, 16'hFFFF);
        cdb(0, 4'd5, 16'h5A5A);
        cycle();
        cycle();
        flush(4'd9);
        disp(2, 16'h00AB);
        cycle();
        drain();

        // Advance head to 14, then dispatch across the wrap and retire in order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp((i == 3) ? 2 : 4, 16'($urandom));
            cycle();
            drain();
        end
        disp(4, 16'hDCBA);
        cycle();
        cdb(0, 4'd1, 16'h0101);
        cdb(1, 4'd0, 16'h0000);
        cdb(2, 4'd15, 16'h1515);
        cdb(3, 4'd14, 16'h1414);
        cycle();
        cycle();
        cycle();

        // Finished-view timing for a single CDB write to tag 2
        disp(4, 16'h7654);
        cycle();
        cdb(0, 4'd2, 16'h1234);
        cycle();
        cycle();
        drain();

        // Randomised traffic with duplicates, stray tags and occasional flushes
        for (int c = 0; c < 300; c++) begin
            n = $urandom_range(0, 4);
            disp(n, 16'($urandom));
            for (int l = 0; l < CW; l++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (q.size() > 0 && $urandom_range(0, 3) != 0)
                        t = q[$urandom_range(0, q.size() - 1)].tag;
                    else
                        t = 4'($urandom);
                    cdb(l, t, 16'($urandom));
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    flush(q[$urandom_range(0, q.size() - 1)].tag);
                else
                    flush(4'($urandom));
            end
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
